// File: rtl/axi_arp_tx.sv
// ARP frame serialiser: latches one request, streams Ethernet II + ARP bytes on 8-bit AXI4-Stream.
// Latency: first byte valid the cycle after the request is sampled; one byte per cycle thereafter.
// Backpressure: tdata/tlast/tvalid hold while tready is low; requests are only sampled when idle.
module axi_arp_tx #(
  parameter int          PAD_EN    = 1,
  parameter logic [47:0] ETH_BCAST = 48'hffffffffffff
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        arp_tx_req,
  output logic        arp_tx_ack,
  input  logic [15:0] arp_tx_opcode,
  input  logic [47:0] arp_tx_src_mac,
  input  logic [31:0] arp_tx_src_ip,
  input  logic [47:0] arp_tx_dst_mac,
  input  logic [31:0] arp_tx_dst_ip,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // Index of the final byte: padded frames end at the 60-byte minimum.
  localparam logic [5:0] L_LAST = (PAD_EN != 0) ? 6'd59 : 6'd41;

  logic [0:0]  r_state;
  logic [5:0]  r_cnt;
  logic [15:0] r_opcode;
  logic [47:0] r_src_mac;
  logic [31:0] r_src_ip;
  logic [47:0] r_dst_mac;
  logic [31:0] r_dst_ip;
  logic        r_ack;
  logic        r_tvalid;
  logic        r_tlast;
  logic [7:0]  r_tdata;

  logic        w_op_ok;
  logic        w_xfer;
  logic [5:0]  w_cnt_nxt;

  // Byte at position idx of the frame built from the given fields (big-endian per field).
  function automatic logic [7:0] frame_byte(
    input logic [5:0]  idx,
    input logic [15:0] op,
    input logic [47:0] smac,
    input logic [31:0] sip,
    input logic [47:0] dmac,
    input logic [31:0] dip
  );
    logic [47:0] eth_dst;
    logic [47:0] tha;
    logic [47:0] sh48;
    logic [31:0] sh32;
    logic [5:0]  k;
    logic [7:0]  b;
    eth_dst = (op == 16'd1) ? ETH_BCAST : dmac;
    tha     = (op == 16'd1) ? 48'd0 : dmac;
    sh48    = 48'd0;
    sh32    = 32'd0;
    k       = 6'd0;
    b       = 8'h00;
    if (idx <= 6'd5) begin
      sh48 = eth_dst << {idx, 3'b000};
      b    = sh48[47:40];
    end else if (idx <= 6'd11) begin
      k    = idx - 6'd6;
      sh48 = smac << {k, 3'b000};
      b    = sh48[47:40];
    end else if (idx <= 6'd21) begin
      case (idx)
        6'd12:   b = 8'h08;
        6'd13:   b = 8'h06;
        6'd14:   b = 8'h00;
        6'd15:   b = 8'h01;
        6'd16:   b = 8'h08;
        6'd17:   b = 8'h00;
        6'd18:   b = 8'h06;
        6'd19:   b = 8'h04;
        6'd20:   b = op[15:8];
        default: b = op[7:0];
      endcase
    end else if (idx <= 6'd27) begin
      k    = idx - 6'd22;
      sh48 = smac << {k, 3'b000};
      b    = sh48[47:40];
    end else if (idx <= 6'd31) begin
      k    = idx - 6'd28;
      sh32 = sip << {k, 3'b000};
      b    = sh32[31:24];
    end else if (idx <= 6'd37) begin
      k    = idx - 6'd32;
      sh48 = tha << {k, 3'b000};
      b    = sh48[47:40];
    end else if (idx <= 6'd41) begin
      k    = idx - 6'd38;
      sh32 = dip << {k, 3'b000};
      b    = sh32[31:24];
    end
    return b;
  endfunction

  assign w_op_ok   = (arp_tx_opcode == 16'd1) || (arp_tx_opcode == 16'd2);
  assign w_xfer    = r_tvalid && m_axis_tready;
  assign w_cnt_nxt = r_cnt + 6'd1;

  // Request acceptance, field latching and byte sequencing with registered stream outputs.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_opcode  <= 16'd0;
      r_src_mac <= 48'd0;
      r_src_ip  <= 32'd0;
      r_dst_mac <= 48'd0;
      r_dst_ip  <= 32'd0;
      r_ack     <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= 8'h00;
    end else begin
      r_ack <= 1'b0;
      if (r_state == S_IDLE) begin
        if (arp_tx_req) begin
          r_opcode  <= arp_tx_opcode;
          r_src_mac <= arp_tx_src_mac;
          r_src_ip  <= arp_tx_src_ip;
          r_dst_mac <= arp_tx_dst_mac;
          r_dst_ip  <= arp_tx_dst_ip;
          r_ack     <= 1'b1;
          // Unknown opcodes are acknowledged but dropped silently.
          if (w_op_ok) begin
            r_state  <= S_SEND;
            r_cnt    <= 6'd0;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_tdata  <= frame_byte(6'd0, arp_tx_opcode, arp_tx_src_mac,
                                   arp_tx_src_ip, arp_tx_dst_mac, arp_tx_dst_ip);
          end
        end
      end else if (w_xfer) begin
        if (r_cnt == L_LAST) begin
          r_state  <= S_IDLE;
          r_cnt    <= 6'd0;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
          r_tdata  <= 8'h00;
        end else begin
          r_cnt   <= w_cnt_nxt;
          r_tlast <= (w_cnt_nxt == L_LAST);
          r_tdata <= frame_byte(w_cnt_nxt, r_opcode, r_src_mac,
                                r_src_ip, r_dst_mac, r_dst_ip);
        end
      end
    end
  end

  assign arp_tx_ack    = r_ack;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tdata  = r_tdata;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_axi_arp_tx.sv
// Bench for axi_arp_tx: padded instance for single frames, unpadded instance for back-to-back.
// Latency: n/a.
// Backpressure: tready randomised on the padded instance to exercise stall hold.
module tb_axi_arp_tx;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] opcode = 16'd0;
  logic [47:0] src_mac = 48'd0;
  logic [31:0] src_ip = 32'd0;
  logic [47:0] dst_mac = 48'd0;
  logic [31:0] dst_ip = 32'd0;

  logic        req0 = 1'b0, tready0 = 1'b0;
  logic        ack0, tvalid0, tlast0, busy0;
  logic [7:0]  tdata0;
  logic        req1 = 1'b0, tready1 = 1'b0;
  logic        ack1, tvalid1, tlast1, busy1;
  logic [7:0]  tdata1;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] cap2_q[$];

  int nacks, nbusy, nstab;
  bit got_last;

  always #5 clk = ~clk;

  axi_arp_tx #(.PAD_EN(1)) u_pad (
    .clk(clk), .areset(areset), .arp_tx_req(req0), .arp_tx_ack(ack0),
    .arp_tx_opcode(opcode), .arp_tx_src_mac(src_mac), .arp_tx_src_ip(src_ip),
    .arp_tx_dst_mac(dst_mac), .arp_tx_dst_ip(dst_ip),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready0),
    .m_axis_tlast(tlast0), .busy(busy0)
  );

  axi_arp_tx #(.PAD_EN(0)) u_nopad (
    .clk(clk), .areset(areset), .arp_tx_req(req1), .arp_tx_ack(ack1),
    .arp_tx_opcode(opcode), .arp_tx_src_mac(src_mac), .arp_tx_src_ip(src_ip),
    .arp_tx_dst_mac(dst_mac), .arp_tx_dst_ip(dst_ip),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
    .m_axis_tlast(tlast1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame from the field layout table.
  task automatic build_exp(input bit pad);
    logic [47:0] ed;
    logic [47:0] tha;
    exp_q.delete();
    ed  = (opcode == 16'd1) ? 48'hffffffffffff : dst_mac;
    tha = (opcode == 16'd1) ? 48'd0 : dst_mac;
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(ed >> (8 * i)));
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(src_mac >> (8 * i)));
    exp_q.push_back(8'h08); exp_q.push_back(8'h06);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    exp_q.push_back(8'h06); exp_q.push_back(8'h04);
    exp_q.push_back(8'(opcode >> 8)); exp_q.push_back(8'(opcode));
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(src_mac >> (8 * i)));
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'(src_ip >> (8 * i)));
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(tha >> (8 * i)));
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'(dst_ip >> (8 * i)));
    if (pad) while (exp_q.size() < 60) exp_q.push_back(8'h00);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, cap_q[i]}, {24'd0, exp_q[i]});
  endtask

  // Issue one request on the padded instance and capture the frame; pct = tready duty in percent.
  task automatic do_frame0(input int pct);
    bit         prev_stall;
    logic [7:0] pd;
    logic       pl;
    cap_q.delete();
    nacks = 0; nbusy = 0; nstab = 0; got_last = 0;
    prev_stall = 0; pd = 8'h00; pl = 1'b0;
    req0 = 1'b1;
    for (int c = 0; c < 3000 && !got_last; c++) begin
      @(posedge clk); #1;
      if (ack0) begin nacks++; req0 = 1'b0; end
      if (busy0) nbusy++;
      if (prev_stall && !(tvalid0 && tdata0 == pd && tlast0 == pl)) nstab++;
      tready0 = ($urandom_range(99) < pct);
      prev_stall = tvalid0 && !tready0;
      pd = tdata0; pl = tlast0;
      if (tvalid0 && tready0) begin
        cap_q.push_back(tdata0);
        if (tlast0) got_last = 1;
      end
    end
    check("got_last", {31'd0, got_last}, 32'd1);
    check("acks", nacks, 1);
    check("stall_hold", nstab, 0);
    @(posedge clk); #1;
    tready0 = 1'b0;
    check("post_tvalid", {31'd0, tvalid0}, 32'd0);
    check("post_busy", {31'd0, busy0}, 32'd0);
  endtask

  int n, acks, frames, gap;

  initial begin
    // Reset state
    tready0 = 1'b1; tready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack0}, 32'd0);
    check("rst_tvalid", {31'd0, tvalid0}, 32'd0);
    check("rst_tlast", {31'd0, tlast0}, 32'd0);
    check("rst_tdata", {24'd0, tdata0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    areset = 1'b0;
    @(posedge clk); #1;

    // 1: REPLY frame, tready high
    opcode = 16'd2; src_mac = 48'h010203040506; src_ip = 32'hc0a80602;
    dst_mac = 48'haabbccddeeff; dst_ip = 32'hc0a80601;
    build_exp(1'b1);
    do_frame0(100);
    compare_stream("reply");
    check("reply_busy_cycles", nbusy, 60);

    // 2: REQUEST frame
    opcode = 16'd1;
    build_exp(1'b1);
    do_frame0(100);
    compare_stream("request");

    // 3: REPLY under ~30% tready
    opcode = 16'd2;
    build_exp(1'b1);
    do_frame0(30);
    compare_stream("bp");

    // 4: invalid opcode is acked and dropped
    opcode = 16'd0; req0 = 1'b1;
    @(posedge clk); #1;
    check("inv_ack", {31'd0, ack0}, 32'd1);
    check("inv_tvalid", {31'd0, tvalid0}, 32'd0);
    check("inv_busy", {31'd0, busy0}, 32'd0);
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("inv_quiet", {29'd0, ack0, tvalid0, busy0}, 32'd0);
    end
    opcode = 16'd2;
    build_exp(1'b1);
    do_frame0(100);
    compare_stream("after_inv");

    // 5: reset after byte 20 has transferred
    tready0 = 1'b1; req0 = 1'b1; n = 0;
    for (int c = 0; c < 200 && n < 22; c++) begin
      @(posedge clk); #1;
      if (ack0) req0 = 1'b0;
      if (tvalid0) n++;
    end
    check("rst_reach", n, 22);
    req0 = 1'b1; areset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tvalid", {31'd0, tvalid0}, 32'd0);
    check("mid_rst_tlast", {31'd0, tlast0}, 32'd0);
    check("mid_rst_ack", {31'd0, ack0}, 32'd0);
    check("mid_rst_busy", {31'd0, busy0}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_ack2", {31'd0, ack0}, 32'd0);
    areset = 1'b0;
    do_frame0(100);
    compare_stream("after_rst");

    // Randomised frames against the reference model
    for (int r = 0; r < 4; r++) begin
      opcode  = 16'($urandom_range(2, 1));
      src_mac = {16'($urandom), $urandom};
      src_ip  = $urandom;
      dst_mac = {16'($urandom), $urandom};
      dst_ip  = $urandom;
      build_exp(1'b1);
      do_frame0($urandom_range(100, 20));
      compare_stream($sformatf("rnd%0d", r));
    end

    // 6: unpadded, back-to-back REPLY with req held high
    opcode = 16'd2; src_mac = 48'h0a0b0c0d0e0f; src_ip = 32'h0a000001;
    dst_mac = 48'h112233445566; dst_ip = 32'h0a000002;
    build_exp(1'b0);
    cap_q.delete(); cap2_q.delete();
    acks = 0; frames = 0; gap = 0;
    tready1 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 400 && frames < 2; c++) begin
      @(posedge clk); #1;
      if (ack1) begin acks++; if (acks >= 2) req1 = 1'b0; end
      if (tvalid1) begin
        if (frames == 0) cap_q.push_back(tdata1);
        else cap2_q.push_back(tdata1);
        if (tlast1) begin
          check("b2b_tlast_pos", (frames == 0) ? cap_q.size() : cap2_q.size(), 42);
          frames++;
        end
      end else if (frames == 1) gap++;
    end
    req1 = 1'b0;
    check("b2b_frames", frames, 2);
    check("b2b_acks", acks, 2);
    check("b2b_gap", gap, 1);
    compare_stream("b2b_f1");
    cap_q = cap2_q;
    compare_stream("b2b_f2");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("b2b_quiet", {29'd0, ack1, tvalid1, busy1}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
